mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/conv_pkg.sv | 18 +
 rtl/mac_accumulator_if.sv | 28 ++
 rtl/acc_adder.sv | 26 ++
 rtl/mac_accumulator.sv | 104 ++++++++++
 tb/tb_mac_accumulator.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared defaults, width derivation and FSM state encoding for the MAC accumulator slice.
package conv_pkg;

   localparam int unsigned PROD_W_DEF = 16;
   localparam int unsigned TAPS_DEF   = 9;

   // Accumulator width wide enough to hold TAPS full-scale products without loss.
   function automatic int unsigned acc_w_f(input int unsigned prod_w, input int unsigned taps);
      return prod_w + $clog2(taps);
   endfunction

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / sum-out handshake bundle between the multiplier stage, accumulator and consumer.
interface mac_accumulator_if #(
   parameter int unsigned PROD_W = conv_pkg::PROD_W_DEF,
   parameter int unsigned TAPS   = conv_pkg::TAPS_DEF,
   parameter int unsigned ACC_W  = conv_pkg::acc_w_f(PROD_W, TAPS)
);
   localparam int unsigned IDX_W = $clog2(TAPS) + 1;

   logic [PROD_W-1:0] product;
   logic              prod_valid;
   logic              prod_ready;
   logic              clear;
   logic [ACC_W-1:0]  sum;
   logic              sum_valid;
   logic              sum_ready;
   logic [IDX_W-1:0]  tap_idx;

   modport master (
      output product, prod_valid, clear, sum_ready,
      input  prod_ready, sum, sum_valid, tap_idx
   );

   modport slave (
      input  product, prod_valid, clear, sum_ready,
      output prod_ready, sum, sum_valid, tap_idx
   );

endinterface

// File: rtl/acc_adder.sv
// Unsigned ACC_W-bit accumulate adder; product is zero-extended.
// ACC_SAT_EN: clamp to all-ones on carry-out instead of wrapping.
module acc_adder #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 20
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum_c
);

`ifdef ACC_SAT_EN
   logic [ACC_W:0] full;

   // Once clamped, any further non-negative add carries out again, so the clamp sticks.
   always_comb begin
      full  = (ACC_W+1)'(a) + (ACC_W+1)'(b);
      sum_c = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
   end
`else
   always_comb begin
      sum_c = a + ACC_W'(b);
   end
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Sums TAPS unsigned products per window and presents the result with a valid/ready handshake.
// Optional ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mac_accumulator
   import conv_pkg::*;
#(
   parameter int unsigned PROD_W = PROD_W_DEF,
   parameter int unsigned TAPS   = TAPS_DEF,
   parameter int unsigned ACC_W  = acc_w_f(PROD_W, TAPS)
) (
   input  logic           clock,
   input  logic           reset_n,
   mac_accumulator_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(TAPS) + 1;

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  acc, acc_nxt;
   logic [IDX_W-1:0]  idx_q, idx_nxt;
   logic [ACC_W-1:0]  sum_q;
   logic              prod_ready_q;
   logic              sum_valid_q;
   logic [ACC_W-1:0]  add_a;
   logic [ACC_W-1:0]  add_c;
   logic              xfer;

   // First product of a window starts from zero rather than the stale accumulator.
   assign add_a = (state == IDLE) ? '0 : acc;
   assign xfer  = bus.prod_valid & prod_ready_q;

   acc_adder #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_adder (
      .a     (add_a),
      .b     (bus.product),
      .sum_c (add_c)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-datapath logic; clear wins over a same-cycle product.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      idx_nxt   = idx_q;
      case (state)
         IDLE, ACCUM: begin
            if (bus.clear) begin
               state_nxt = IDLE;
               acc_nxt   = '0;
               idx_nxt   = '0;
            end else if (xfer) begin
               acc_nxt   = add_c;
               idx_nxt   = (state == IDLE) ? IDX_W'(1) : idx_q + IDX_W'(1);
               state_nxt = (idx_nxt == IDX_W'(TAPS)) ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (bus.sum_ready) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc          <= '0;
         idx_q        <= '0;
         sum_q        <= '0;
         prod_ready_q <= 1'b0;
         sum_valid_q  <= 1'b0;
      end else begin
         acc          <= acc_nxt;
         idx_q        <= idx_nxt;
         prod_ready_q <= (state_nxt != DONE);
         sum_valid_q  <= (state_nxt == DONE);
         if (state_nxt == DONE && state != DONE) begin
            sum_q <= acc_nxt;
         end
      end
   end

   assign bus.prod_ready = prod_ready_q;
   assign bus.sum_valid  = sum_valid_q;
   assign bus.sum        = sum_q;
   assign bus.tap_idx    = idx_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: default 9-tap instance plus a 2-tap/16-bit overflow instance.
module tb_mac_accumulator;

   logic clock;
   logic reset_n;

   int total = 0;
   int bad   = 0;

   logic [19:0] q[$];
   logic [15:0] q2[$];
   logic [19:0] exp_main;
   logic [15:0] exp_small;

   mac_accumulator_if #(.PROD_W(16), .TAPS(9), .ACC_W(20)) bus ();
   mac_accumulator_if #(.PROD_W(16), .TAPS(2), .ACC_W(16)) sbus ();

   mac_accumulator #(.PROD_W(16), .TAPS(9), .ACC_W(20)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   mac_accumulator #(.PROD_W(16), .TAPS(2), .ACC_W(16)) dut_small (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (sbus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want done");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Completed sums leave the DUT on the edge after a negedge that sees valid & ready.
   always @(negedge clock) begin
      if (reset_n && bus.sum_valid && bus.sum_ready) begin
         chk("sb_pending", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            exp_main = q.pop_front();
            chk("sum", 32'(bus.sum), 32'(exp_main));
            chk("tap_idx_done", 32'(bus.tap_idx), 32'd9);
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n && sbus.sum_valid && sbus.sum_ready) begin
         chk("sb2_pending", 32'(q2.size() != 0), 32'd1);
         if (q2.size() != 0) begin
            exp_small = q2.pop_front();
            chk("sum_small", 32'(sbus.sum), 32'(exp_small));
            chk("tap_idx_small", 32'(sbus.tap_idx), 32'd2);
         end
      end
   end

   // Tasks start and end at posedge+1; inputs change only there.
   task automatic idle(input int n);
      bus.prod_valid = 1'b0;
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic push(input logic [15:0] p, input int bub, input int idx);
      int n;
      for (int b = 0; b < bub; b++) begin
         bus.prod_valid = 1'b0;
         @(posedge clock); #1;
         chk("hold_idx", 32'(bus.tap_idx), 32'(idx));
      end
      bus.product    = p;
      bus.prod_valid = 1'b1;
      n = 0;
      while (!bus.prod_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= 50) chk("ready_timeout", 32'(bus.prod_ready), 32'd1);
      @(posedge clock); #1;
   endtask

   task automatic window(input logic [15:0] p, input int n, input int maxb);
      logic [19:0] e;
      e = '0;
      for (int i = 0; i < n; i++) e = e + 20'(p);
      q.push_back(e);
      for (int i = 0; i < n; i++) begin
         push(p, (maxb == 0) ? 0 : int'($urandom_range(1, maxb)), i);
      end
   endtask

   task automatic small_push(input logic [15:0] p);
      int n;
      sbus.product    = p;
      sbus.prod_valid = 1'b1;
      n = 0;
      while (!sbus.prod_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= 50) chk("ready_timeout_small", 32'(sbus.prod_ready), 32'd1);
      @(posedge clock); #1;
   endtask

   initial begin
      logic [16:0] t2;
      int n;

      reset_n         = 1'b0;
      bus.product     = '0;
      bus.prod_valid  = 1'b0;
      bus.clear       = 1'b0;
      bus.sum_ready   = 1'b1;
      sbus.product    = '0;
      sbus.prod_valid = 1'b0;
      sbus.clear      = 1'b0;
      sbus.sum_ready  = 1'b1;

      // Reset state
      #3;
      chk("rst_prod_ready", 32'(bus.prod_ready), 32'd0);
      chk("rst_sum_valid",  32'(bus.sum_valid),  32'd0);
      chk("rst_sum",        32'(bus.sum),        32'd0);
      chk("rst_tap_idx",    32'(bus.tap_idx),    32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("ready_before_edge", 32'(bus.prod_ready), 32'd0);
      @(posedge clock); #1;
      chk("ready_after_edge", 32'(bus.prod_ready), 32'd1);

      // Two-tap 16-bit instance: 65025 + 65025 overflows the accumulator
      t2 = 17'(16'd65025) + 17'(16'd65025);
`ifdef ACC_SAT_EN
      q2.push_back(t2[16] ? 16'hFFFF : t2[15:0]);
`else
      q2.push_back(t2[15:0]);
`endif
      small_push(16'd65025);
      small_push(16'd65025);
      sbus.prod_valid = 1'b0;
      chk("small_valid", 32'(sbus.sum_valid), 32'd1);
      idle(2);

      // Nine back-to-back products; valid one cycle after the ninth capture
      window(16'd14450, 9, 0);
      bus.prod_valid = 1'b0;
      chk("latency_valid", 32'(bus.sum_valid), 32'd1);
      chk("latency_idx",   32'(bus.tap_idx),   32'd9);
      idle(2);

      // Same window with random 1-3 cycle bubbles
      window(16'd14450, 9, 3);
      idle(2);

      // Stall in DONE with a pending product and a clear pulse
      bus.sum_ready = 1'b0;
      window(16'd14450, 9, 0);
      bus.product    = 16'd7;
      bus.prod_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.clear = (i == 2);
         @(posedge clock); #1;
         chk("stall_ready", 32'(bus.prod_ready), 32'd0);
         chk("stall_valid", 32'(bus.sum_valid),  32'd1);
         chk("stall_sum",   32'(bus.sum),        32'd130050);
         chk("stall_idx",   32'(bus.tap_idx),    32'd9);
      end
      bus.clear      = 1'b0;
      bus.prod_valid = 1'b0;
      bus.sum_ready  = 1'b1;
      @(posedge clock); #1;
      chk("post_stall_idx",   32'(bus.tap_idx),   32'd0);
      chk("post_stall_valid", 32'(bus.sum_valid), 32'd0);
      idle(1);

      // clear together with the fourth product aborts the window
      for (int i = 0; i < 3; i++) push(16'd100, 0, i);
      bus.product    = 16'd100;
      bus.prod_valid = 1'b1;
      bus.clear      = 1'b1;
      @(posedge clock); #1;
      bus.clear      = 1'b0;
      bus.prod_valid = 1'b0;
      chk("clear_idx",   32'(bus.tap_idx),   32'd0);
      chk("clear_valid", 32'(bus.sum_valid), 32'd0);
      window(16'd100, 9, 0);
      idle(2);

      // Asynchronous reset mid-window, then a fresh window
      for (int i = 0; i < 5; i++) push(16'd1, 0, i);
      bus.prod_valid = 1'b0;
      chk("pre_reset_idx", 32'(bus.tap_idx), 32'd5);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_prod_ready", 32'(bus.prod_ready), 32'd0);
      chk("arst_sum_valid",  32'(bus.sum_valid),  32'd0);
      chk("arst_sum",        32'(bus.sum),        32'd0);
      chk("arst_tap_idx",    32'(bus.tap_idx),    32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rel_ready_before", 32'(bus.prod_ready), 32'd0);
      @(posedge clock); #1;
      chk("rel_ready_after", 32'(bus.prod_ready), 32'd1);
      window(16'd1, 9, 0);

      // Drain the scoreboards within a bounded number of cycles
      n = 0;
      bus.prod_valid = 1'b0;
      while ((q.size() != 0 || q2.size() != 0) && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      idle(2);
      chk("sb_drain",  32'(q.size()),  32'd0);
      chk("sb2_drain", 32'(q2.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
